// File: rtl/fpu_pkg.sv
// Shared FP-unit definitions: register-file geometry, the writeback entry
// layout and the fsub pipeline depth that sizes issue back-pressure.
package fpu_pkg;

    localparam int REG_AW      = 5;
    localparam int FP_W        = 32;
    localparam int FSUB_NSTAGE = 2;
    localparam int WB_EW       = REG_AW + FP_W;

    typedef struct packed {
        logic [REG_AW-1:0] add;
        logic [FP_W-1:0]   data;
    } wb_entry_t;

endpackage

// File: rtl/fsub_wb_fifo.sv
// In-order storage for fsub writeback entries: circular array, read/write
// pointers and occupancy. The head entry is held in a register that is
// loaded from the array at the next read pointer, so the head stays put
// while nothing is popped and keeps its last value once the FIFO empties.
// Optional macro FSUB_WB_FWD_EN exposes the raw array and read pointer for
// the forwarding lookup in the parent.
module fsub_wb_fifo
    import fpu_pkg::*;
#(
    parameter int  DEPTH = 4,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 push_i,
    input  logic                 pop_i,
    input  logic [WB_EW-1:0]     wr_entry_i,
    output logic [WB_EW-1:0]     head_o,
    output logic                 full_o,
    output logic                 empty_o,
    output logic [CW-1:0]        count_o,
`ifdef FSUB_WB_FWD_EN
    output logic [DEPTH*WB_EW-1:0] entries_o,
    output logic [PW-1:0]        rptr_o,
`endif
    output logic [CW-1:0]        count_next_o
);

    wb_entry_t     mem_q [DEPTH];
    wb_entry_t     wr_entry;
    wb_entry_t     head_q, head_d;
    logic [PW-1:0] wptr_q, wptr_d;
    logic [PW-1:0] rptr_q, rptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          push_ok, pop_ok;

    assign wr_entry = wr_entry_i;
    assign full_o   = (count_q == CW'(DEPTH));
    assign empty_o  = (count_q == '0);
    // A pop frees a slot in the same cycle, so a push into a full FIFO is
    // accepted when it coincides with a pop.
    assign pop_ok   = pop_i && !empty_o;
    assign push_ok  = push_i && (!full_o || pop_ok);

    // Pointer and occupancy update for this cycle's push/pop.
    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (push_ok) begin
            wptr_d = wptr_q + 1'b1;
        end
        if (pop_ok) begin
            rptr_d = rptr_q + 1'b1;
        end
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Next head: the entry at the new read pointer, bypassing the array when
    // that slot is the one being written this cycle; held when going empty.
    always_comb begin
        head_d = head_q;
        if (count_d != '0) begin
            if (push_ok && (wptr_q == rptr_d)) begin
                head_d = wr_entry;
            end else begin
                head_d = mem_q[rptr_d];
            end
        end
    end

    // Storage array write; contents need no reset since occupancy gates use.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wptr_q] <= wr_entry;
        end
    end

    // Pointer, occupancy and head registers.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            head_q  <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            head_q  <= head_d;
        end
    end

    assign head_o       = head_q;
    assign count_o      = count_q;
    assign count_next_o = count_d;

`ifdef FSUB_WB_FWD_EN
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entries
        assign entries_o[gi*WB_EW +: WB_EW] = mem_q[gi];
    end
    assign rptr_o = rptr_q;
`endif

endmodule

// File: rtl/fsub_wb_buffer.sv
// Writeback buffer between the non-stallable fsub pipeline and the shared FP
// register-file write port. Results are queued in order and drained under a
// valid/ready handshake; issue is stalled early enough that results already
// in flight inside fsub still fit. A result that cannot be stored sets a
// sticky overflow flag.
// Optional macro FSUB_WB_FWD_EN adds a combinational lookup (fwd_add,
// fwd_hit, fwd_data) returning the newest buffered value for a register.
// AW and DW must match the entry layout in fpu_pkg.
module fsub_wb_buffer
    import fpu_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int SLACK = FSUB_NSTAGE,
    parameter int AW    = REG_AW,
    parameter int DW    = FP_W
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic                         in_flag,
    input  logic [AW-1:0]                in_add,
    input  logic [DW-1:0]                in_data,
    input  logic                         wb_ready,
    output logic                         wb_valid,
    output logic [AW-1:0]                wb_add,
    output logic [DW-1:0]                wb_data,
    output logic                         stall_issue,
    output logic                         overflow,
`ifdef FSUB_WB_FWD_EN
    input  logic [AW-1:0]                fwd_add,
    output logic                         fwd_hit,
    output logic [DW-1:0]                fwd_data,
`endif
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);

    wb_entry_t     in_entry;
    wb_entry_t     head;
    logic          full, empty;
    logic [CW-1:0] count_next;
    logic          overflow_q, overflow_d;
    logic          stall_q, stall_d;
    logic          drop;

    assign in_entry.add  = in_add;
    assign in_entry.data = in_data;

`ifdef FSUB_WB_FWD_EN
    logic [DEPTH*WB_EW-1:0] entries;
    logic [PW-1:0]          rptr;
`endif

    fsub_wb_fifo #(
        .DEPTH        (DEPTH)
    ) u_fifo (
        .clk          (clk),
        .rstn         (rstn),
        .push_i       (in_flag),
        .pop_i        (wb_ready),
        .wr_entry_i   (in_entry),
        .head_o       (head),
        .full_o       (full),
        .empty_o      (empty),
        .count_o      (count),
`ifdef FSUB_WB_FWD_EN
        .entries_o    (entries),
        .rptr_o       (rptr),
`endif
        .count_next_o (count_next)
    );

    assign wb_valid = !empty;
    assign wb_add   = head.add;
    assign wb_data  = head.data;

    // A result is lost only when full and the head is not leaving this cycle.
    assign drop       = in_flag && full && !(wb_ready && !empty);
    assign overflow_d = overflow_q || drop;
    // Stall once free space after this edge no longer covers in-flight ops.
    assign stall_d    = (DEPTH - int'(count_next)) <= SLACK;

    // Sticky overflow flag and registered issue stall.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            overflow_q <= 1'b0;
            stall_q    <= 1'b0;
        end else begin
            overflow_q <= overflow_d;
            stall_q    <= stall_d;
        end
    end

    assign overflow    = overflow_q;
    assign stall_issue = stall_q;

`ifdef FSUB_WB_FWD_EN
    logic [PW-1:0] slot;
    wb_entry_t     cand;

    // Scan valid entries oldest to newest so the newest match wins; the head
    // still counts while it is being popped this cycle.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        slot     = '0;
        cand     = '0;
        for (int i = 0; i < DEPTH; i++) begin
            slot = rptr + PW'(i);
            cand = entries[int'(slot)*WB_EW +: WB_EW];
            if ((CW'(i) < count) && (cand.add == fwd_add)) begin
                fwd_hit  = 1'b1;
                fwd_data = cand.data;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fsub_wb_buffer.sv
// Scoreboard bench for fsub_wb_buffer: the stimulus side keeps a queue model
// of the buffer and queues expected status and writeback entries; a monitor
// on the falling edge compares the DUT against them.
module tb_fsub_wb_buffer;
    import fpu_pkg::*;

    localparam int DEPTH = 4;
    localparam int SLACK = 2;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        in_flag = 1'b0;
    logic [4:0]  in_add = '0;
    logic [31:0] in_data = '0;
    logic        wb_ready = 1'b0;
    logic        wb_valid;
    logic [4:0]  wb_add;
    logic [31:0] wb_data;
    logic        stall_issue;
    logic        overflow;
    logic [2:0]  count;
`ifdef FSUB_WB_FWD_EN
    logic [4:0]  fwd_add = '0;
    logic        fwd_hit;
    logic [31:0] fwd_data;
`endif

    always #5 clk = ~clk;

    fsub_wb_buffer #(
        .DEPTH       (DEPTH),
        .SLACK       (SLACK),
        .AW          (5),
        .DW          (32)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .in_flag     (in_flag),
        .in_add      (in_add),
        .in_data     (in_data),
        .wb_ready    (wb_ready),
        .wb_valid    (wb_valid),
        .wb_add      (wb_add),
        .wb_data     (wb_data),
        .stall_issue (stall_issue),
        .overflow    (overflow),
`ifdef FSUB_WB_FWD_EN
        .fwd_add     (fwd_add),
        .fwd_hit     (fwd_hit),
        .fwd_data    (fwd_data),
`endif
        .count       (count)
    );

    typedef struct {
        int        cnt;
        bit        ovf;
        bit        stall;
        wb_entry_t last;
    } stat_t;

    wb_entry_t mdl[$];
    wb_entry_t exp_q[$];
    stat_t     stat_q[$];
    bit        mdl_ovf = 1'b0;
    wb_entry_t mdl_last = '0;
    int        n_checks = 0;
    int        n_fail = 0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at t=%0t", name, act, req, $time);
        end
    endtask

    // One clock cycle of stimulus; the model advances with the same inputs.
    task automatic cyc(bit flag, logic [4:0] a, logic [31:0] d, bit rdy, bit rst_n);
        stat_t     st;
        wb_entry_t e;
        rstn     = rst_n;
        in_flag  = flag;
        in_add   = a;
        in_data  = d;
        wb_ready = rdy;
        e.add    = a;
        e.data   = d;
        @(posedge clk);
        if (!rst_n) begin
            mdl.delete();
            exp_q.delete();
            mdl_ovf  = 1'b0;
            mdl_last = '0;
        end else begin
            if (rdy && mdl.size() != 0) begin
                mdl_last = mdl.pop_front();
            end
            if (flag) begin
                if (mdl.size() < DEPTH) begin
                    mdl.push_back(e);
                    exp_q.push_back(e);
                end else begin
                    mdl_ovf = 1'b1;
                end
            end
        end
        st.cnt   = mdl.size();
        st.ovf   = mdl_ovf;
        st.stall = (DEPTH - mdl.size()) <= SLACK;
        st.last  = mdl_last;
        stat_q.push_back(st);
        #1;
    endtask

    // Monitor: status after each edge, head/handshake, optional forwarding.
    always @(negedge clk) begin
        stat_t       st;
        wb_entry_t   e;
        bit          h;
        logic [31:0] fd;
        if (stat_q.size() != 0) begin
            st = stat_q.pop_front();
            chk("count", 32'(count), 32'(st.cnt));
            chk("wb_valid", 32'(wb_valid), 32'(st.cnt != 0));
            chk("overflow", 32'(overflow), 32'(st.ovf));
            chk("stall_issue", 32'(stall_issue), 32'(st.stall));
            if (st.cnt == 0) begin
                chk("hold_add", 32'(wb_add), 32'(st.last.add));
                chk("hold_data", wb_data, st.last.data);
            end
        end
`ifdef FSUB_WB_FWD_EN
        h  = 1'b0;
        fd = '0;
        foreach (exp_q[i]) begin
            if (exp_q[i].add == fwd_add) begin
                h  = 1'b1;
                fd = exp_q[i].data;
            end
        end
        chk("fwd_hit", 32'(fwd_hit), 32'(h));
        chk("fwd_data", fwd_data, fd);
`endif
        if (wb_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("spurious_valid", 32'(wb_valid), 32'd0);
            end else begin
                chk("wb_add", 32'(wb_add), 32'(exp_q[0].add));
                chk("wb_data", wb_data, exp_q[0].data);
                if (wb_ready && rstn) begin
                    e = exp_q.pop_front();
                    $display("wb: add=%0d data=%h count=%0d", e.add, e.data, count);
                end
            end
        end
    end

    initial begin
        // Reset, then idle.
        cyc(0, 5'd0, 32'h0, 0, 0);
        cyc(0, 5'd0, 32'h0, 0, 0);
        cyc(0, 5'd0, 32'h0, 0, 1);
        cyc(0, 5'd0, 32'h0, 0, 1);
        // Single pass-through.
        cyc(1, 5'd3, 32'h3F800000, 1, 1);
        cyc(0, 5'd0, 32'h0, 1, 1);
        cyc(0, 5'd0, 32'h0, 1, 1);
        // Fill under back-pressure, hold, then push+pop at full, then overflow.
        for (int i = 0; i < 4; i++) begin
            cyc(1, 5'(i + 1), 32'h40000000 + 32'(i), 0, 1);
        end
        cyc(0, 5'd0, 32'h0, 0, 1);
        cyc(0, 5'd0, 32'h0, 0, 1);
        cyc(1, 5'd9, 32'h00000090, 1, 1);
        cyc(1, 5'd7, 32'h00000070, 0, 1);
        for (int i = 0; i < 6; i++) begin
            cyc(0, 5'd0, 32'h0, 1, 1);
        end
        // Duplicate destination register; forwarding lookup when enabled.
`ifdef FSUB_WB_FWD_EN
        fwd_add = 5'd6;
`endif
        cyc(1, 5'd6, 32'hAAAA0001, 0, 1);
        cyc(1, 5'd6, 32'hBBBB0002, 0, 1);
        cyc(0, 5'd0, 32'h0, 0, 1);
`ifdef FSUB_WB_FWD_EN
        fwd_add = 5'd8;
`endif
        cyc(0, 5'd0, 32'h0, 0, 1);
        // Reset while entries are draining.
        cyc(1, 5'd2, 32'h12345678, 1, 1);
        cyc(0, 5'd0, 32'h0, 1, 0);
        cyc(0, 5'd0, 32'h0, 1, 1);
        // Randomized traffic with alternating drain pressure and rare resets.
        for (int k = 0; k < 1500; k++) begin
            int rdy_pct;
            rdy_pct = ((k / 250) % 2 == 1) ? 80 : 35;
`ifdef FSUB_WB_FWD_EN
            fwd_add = 5'($urandom_range(0, 7));
`endif
            cyc($urandom_range(0, 99) < 60, 5'($urandom_range(0, 7)), $urandom,
                $urandom_range(0, 99) < rdy_pct, $urandom_range(0, 199) != 0);
        end
        cyc(0, 5'd0, 32'h0, 1, 1);
        @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
